// File: rtl/bitwise_pipe.sv
// bitwise_pipe: one of eight bitwise ops on two WIDTH-bit operands, results queued in a DEPTH-entry FIFO.
// Latency: 1 cycle from accepted push to out_valid, no bypass. Backpressure: in_ready drops when full or in reset, never depends on out_ready.
// Optional macro BITWISE_PIPE_PARITY_EN adds a parity output (XOR-reduction of the head result).
module bitwise_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     zr,
    output logic                     ng,
    output logic [$clog2(DEPTH):0]   count
`ifdef BITWISE_PIPE_PARITY_EN
    ,
    output logic                     parity
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_head;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_result = '0;
        case (op)
            3'b000:  w_result = ~a;
            3'b001:  w_result = a & b;
            3'b010:  w_result = a | b;
            3'b011:  w_result = a ^ b;
            3'b100:  w_result = ~(a & b);
            3'b101:  w_result = ~(a | b);
            3'b110:  w_result = ~(a ^ b);
            default: w_result = a;
        endcase
    end

    // in_ready looks only at stored count, so a pop cannot open a slot in the same cycle.
    assign in_ready  = (r_count < DEPTH_C) && !reset;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not cleared; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_result;
    end

    assign w_head = r_mem[r_rd_ptr];
    assign out    = out_valid ? w_head : '0;
    assign zr     = out_valid && (w_head == '0);
    assign ng     = out_valid && w_head[WIDTH-1];
    assign count  = r_count;

`ifdef BITWISE_PIPE_PARITY_EN
    assign parity = out_valid && (^w_head);
`endif

endmodule
